// File: rtl/mem_dma_initiator_if.sv
// Data-memory port between an initiator (control-side DMA) and the RAM.
// mem_rdata is combinational from mem_addr while mem_read is high.
interface mem_dma_initiator_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_dma_initiator.sv
// Memory initiator: single LOAD/STORE and multi-byte FILL/COPY, one access
// per cycle, with a start/busy/done handshake toward the control unit.
module mem_dma_initiator #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    mem_dma_initiator_if.master mem
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    // Write value: latched data_in for STORE/FILL, the read-back byte for COPY.
    logic [DATA_W-1:0] wval_q, wval_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            wval_q     <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            wval_q     <= wval_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cnt_d         = cnt_q;
        wval_d        = wval_q;
        data_out_d    = data_out_q;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    wval_d = data_in;
                    // STORE is a one-byte write, so it reuses the WR countdown.
                    cnt_d  = (op == OP_STORE) ? LEN_W'(1) : len;
                    unique case (op)
                        OP_LOAD:  state_d = RD;
                        OP_STORE: state_d = WR;
                        OP_FILL:  state_d = (len == '0) ? DONE : WR;
                        OP_COPY:  state_d = (len == '0) ? DONE : RD;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            RD: begin
                mem.mem_read = 1'b1;
                mem.mem_addr = src_q;
                if (op_q == OP_LOAD) begin
                    data_out_d = mem.mem_rdata;
                    state_d    = DONE;
                end else begin
                    wval_d  = mem.mem_rdata;
                    src_d   = src_q + ADDR_W'(1);
                    state_d = WR;
                end
            end
            WR: begin
                mem.mem_write = 1'b1;
                mem.mem_addr  = dst_q;
                mem.mem_wdata = wval_q;
                dst_d         = dst_q + ADDR_W'(1);
                cnt_d         = cnt_q - LEN_W'(1);
                if (cnt_d == '0)          state_d = DONE;
                else if (op_q == OP_COPY) state_d = RD;
                else                      state_d = WR;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = data_out_q;
endmodule

// File: tb/tb_mem_dma_initiator.sv
// Directed bench for mem_dma_initiator with a behavioural 256-byte RAM.
module tb_mem_dma_initiator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [3:0] len = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       busy, done;

    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    bit   [7:0] ram [256];

    int checks = 0;
    int failures = 0;
    int both_high = 0;

    mem_dma_initiator_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_dma_initiator #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
        .mem(bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_read ? ram[bus.mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_we)    ram[pl_addr] <= pl_data;
    end

    always @(negedge clk) if (bus.mem_read && bus.mem_write) both_high++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, "_rd"},   {31'd0, bus.mem_read}, 0);
        chk({tag, "_wr"},   {31'd0, bus.mem_write}, 0);
        chk({tag, "_addr"}, {24'd0, bus.mem_addr}, 0);
        chk({tag, "_wd"},   {24'd0, bus.mem_wdata}, 0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                         input logic [3:0] l, input logic [7:0] di);
        start = 1'b1; op = o; src_addr = s; dst_addr = d; len = l; data_in = di;
        step();
        start = 1'b0;
    endtask

    logic [7:0] exp_addr [6];
    logic       exp_rd   [6];
    logic [7:0] exp_wd   [6];

    initial begin
        // Reset held for two cycles
        step(); step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_dout", {24'd0, data_out}, 0);
        chk_idle_port("rst");
        rst = 1'b0;
        step();

        // STORE dst=3 data=A5
        issue(2'b01, 8'h00, 8'h03, 4'd0, 8'hA5);
        chk("st_wr",   {31'd0, bus.mem_write}, 1);
        chk("st_rd",   {31'd0, bus.mem_read}, 0);
        chk("st_addr", {24'd0, bus.mem_addr}, 8'h03);
        chk("st_wd",   {24'd0, bus.mem_wdata}, 8'hA5);
        chk("st_busy", {31'd0, busy}, 1);
        step();
        chk("st_done", {31'd0, done}, 1);
        chk("st_ram",  {24'd0, ram[3]}, 8'hA5);
        chk_idle_port("st_dn");
        step();
        chk("st_idle", {31'd0, busy}, 0);

        // LOAD src=5 with RAM[5]=3C
        preload(8'h05, 8'h3C);
        issue(2'b00, 8'h05, 8'h00, 4'd0, 8'h00);
        chk("ld_rd",   {31'd0, bus.mem_read}, 1);
        chk("ld_addr", {24'd0, bus.mem_addr}, 8'h05);
        chk("ld_dn0",  {31'd0, done}, 0);
        step();
        chk("ld_done", {31'd0, done}, 1);
        chk("ld_dout", {24'd0, data_out}, 8'h3C);
        chk("ld_rdlo", {31'd0, bus.mem_read}, 0);
        step();
        chk("ld_idle", {31'd0, busy}, 0);

        // FILL dst=FE len=3 data=11, with a competing start held high throughout
        issue(2'b10, 8'h00, 8'hFE, 4'd3, 8'h11);
        start = 1'b1; op = 2'b01; dst_addr = 8'h40; len = 4'd1; data_in = 8'h77;
        chk("fl_a0", {24'd0, bus.mem_addr}, 8'hFE);
        chk("fl_w0", {24'd0, bus.mem_wdata}, 8'h11);
        step();
        chk("fl_a1", {24'd0, bus.mem_addr}, 8'hFF);
        chk("fl_w1", {24'd0, bus.mem_wdata}, 8'h11);
        chk("fl_busy1", {31'd0, busy}, 1);
        step();
        chk("fl_a2", {24'd0, bus.mem_addr}, 8'h00);
        chk("fl_wr2", {31'd0, bus.mem_write}, 1);
        step();
        chk("fl_done", {31'd0, done}, 1);
        chk("fl_busy", {31'd0, busy}, 1);
        step();
        start = 1'b0;
        chk("fl_idle", {31'd0, busy}, 0);
        chk("fl_ramFE", {24'd0, ram[8'hFE]}, 8'h11);
        chk("fl_ramFF", {24'd0, ram[8'hFF]}, 8'h11);
        chk("fl_ram00", {24'd0, ram[8'h00]}, 8'h11);
        chk("fl_ram40", {24'd0, ram[8'h40]}, 8'h00);
        step();
        chk("fl_noretrig", {31'd0, busy}, 0);

        // COPY src=0 dst=4 len=3 with RAM[0..2]={1,2,3}
        preload(8'h00, 8'h01); preload(8'h01, 8'h02); preload(8'h02, 8'h03);
        exp_addr = '{8'h00, 8'h04, 8'h01, 8'h05, 8'h02, 8'h06};
        exp_rd   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_wd   = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        issue(2'b11, 8'h00, 8'h04, 4'd3, 8'hEE);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cp_rd%0d", i),   {31'd0, bus.mem_read},  {31'd0, exp_rd[i]});
            chk($sformatf("cp_wr%0d", i),   {31'd0, bus.mem_write}, {31'd0, !exp_rd[i]});
            chk($sformatf("cp_addr%0d", i), {24'd0, bus.mem_addr},  {24'd0, exp_addr[i]});
            chk($sformatf("cp_wd%0d", i),   {24'd0, bus.mem_wdata}, {24'd0, exp_wd[i]});
            step();
        end
        chk("cp_done", {31'd0, done}, 1);
        chk("cp_ram6", {24'd0, ram[6]}, 8'h03);
        chk("cp_dout", {24'd0, data_out}, 8'h3C);
        step();

        // COPY len=0: straight to DONE, no access
        issue(2'b11, 8'h00, 8'h20, 4'd0, 8'h00);
        chk("z_done", {31'd0, done}, 1);
        chk_idle_port("z");
        step();
        chk("z_idle", {31'd0, busy}, 0);

        // Reset during the second WR of a COPY
        issue(2'b11, 8'h00, 8'h08, 4'd3, 8'h00);
        step(); step(); step();
        chk("rc_wr2", {24'd0, bus.mem_addr}, 8'h09);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rc_busy", {31'd0, busy}, 0);
        chk("rc_done", {31'd0, done}, 0);
        chk("rc_dout", {24'd0, data_out}, 0);
        chk_idle_port("rc");
        step();
        chk("rc_done2", {31'd0, done}, 0);
        chk("rc_rd2",   {31'd0, bus.mem_read}, 0);
        chk("rc_ram10", {24'd0, ram[8'h0A]}, 8'h00);

        // LOAD after the abort
        issue(2'b00, 8'h01, 8'h00, 4'd0, 8'h00);
        chk("pl_addr", {24'd0, bus.mem_addr}, 8'h01);
        step();
        chk("pl_done", {31'd0, done}, 1);
        chk("pl_dout", {24'd0, data_out}, 8'h02);
        step();

        chk("never_both", both_high, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
